mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: ADDR_W, default 8, word-address bits; depth = 2^ADDR_W 32-bit words.
REQ-002 Parameter: WAIT_CYCLES, default 2, extra access wait states; legal range 0..15.
REQ-003 The unit SHALL use one clock, clk, with an asynchronous active-low reset, rst_n.
REQ-004 Port: clk  input  1  clock, rising edge active.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: MemRead  input  1  load request.
REQ-007 Port: MemWrite  input  1  store request.
REQ-008 Port: size  input  2  access size: 00 byte, 01 halfword, 10 word, 11 treated as word.
REQ-009 Port: sign_ext  input  1  load result is sign-extended when 1, zero-extended when 0.
REQ-010 Port: aluOut  input  32  byte address.
REQ-011 Port: writeData  input  32  store data, right-justified for byte and halfword stores.
REQ-012 Port: readData  output  32  registered load result.
REQ-013 Port: stall  output  1  pipeline hold request.
REQ-014 Port: done  output  1  one-cycle completion pulse.
REQ-015 Port: misaligned  output  1  one-cycle alignment-fault pulse.

Function
REQ-016 State machine SHALL have two states, IDLE and WAIT, plus a 4-bit wait counter.
REQ-017 A request SHALL be MemRead|MemWrite; when both are high, the access SHALL be a write and the read is ignored.
REQ-018 Alignment fault conditions SHALL be: halfword with aluOut[0]=1; word with aluOut[1:0]!=0.
REQ-019 A misaligned request in IDLE SHALL raise misaligned for exactly the next cycle, with no memory access, no stall, no done and readData unchanged.
REQ-020 An aligned request in IDLE with done=0 SHALL be accepted at the edge: aluOut, writeData, size, sign_ext and the request type are captured, the counter is loaded with WAIT_CYCLES, and the state moves to WAIT.
REQ-021 A request presented in IDLE while done=1 SHALL be ignored, because it is the request that just completed.
REQ-022 stall SHALL be combinational: (IDLE & aligned request & !done) | WAIT.
REQ-023 In WAIT with counter>0, the counter SHALL decrement at each edge.
REQ-024 In WAIT with counter=0, at the edge the unit SHALL perform the access, set done=1 for one cycle, and return to IDLE.
REQ-025 Latency: stall SHALL be high for WAIT_CYCLES+2 cycles, and done SHALL be high in the first cycle after stall falls.
REQ-026 Inputs changing after acceptance SHALL NOT affect the access in progress.
REQ-027 Word index SHALL be aluOut[ADDR_W+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo depth.
REQ-028 Stores SHALL write only the addressed lanes: byte lane aluOut[1:0]; halfword lanes aluOut[1]; all other bytes are preserved.
REQ-029 Loads SHALL extract the addressed byte or halfword into bits [7:0] or [15:0] and extend per sign_ext; word loads SHALL ignore sign_ext.
REQ-030 readData SHALL update only on load completion and SHALL hold its value otherwise, including across stores and faults.

Reset
REQ-031 While rst_n=0, state SHALL be IDLE, counter 0, readData 0x00000000, and done=0, misaligned=0, stall=0.
REQ-032 Reset asserted mid-access SHALL abort the access; an aborted store SHALL NOT modify memory.
REQ-033 Memory array contents SHALL be unaffected by reset and undefined after power-up.

Verification (WAIT_CYCLES=2 unless stated)
REQ-034 Store word 0xDEADBEEF to 0x10, then load word from 0x10 -> each access stalls 4 cycles, done pulses once, readData=0xDEADBEEF.
REQ-035 Store byte 0x80 to 0x13, then: signed byte load 0x13 -> 0xFFFFFF80; unsigned byte load -> 0x00000080; load word 0x10 -> 0x80ADBEEF.
REQ-036 Halfword load at 0x11 -> misaligned=1 for one cycle, stall=0, done=0, readData unchanged.
REQ-037 Word 0x20 holds 0x11111111; store 0x55 to 0x20 with rst_n pulsed low during WAIT -> stall/done drop immediately; load word 0x20 -> 0x11111111.
REQ-038 MemRead=MemWrite=1, store 0x7 to 0x24 -> readData unchanged; load word 0x24 -> 0x00000007.
REQ-039 ADDR_W=8, WAIT_CYCLES=0: store 0xA5 to 0x400, then load word 0x000 -> 0x000000A5, stall 2 cycles per access; back-to-back held requests are not repeated.

Source files
------------

// File: rtl/mem_access_unit.sv
// Multi-cycle data-memory access unit with wait states.
// Handles byte/halfword/word loads and stores, with alignment-fault reporting.
module mem_access_unit #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] aluOut,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        stall,
  output logic        done,
  output logic        misaligned
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W+1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [1:0]          size_q, size_d;
  logic                sext_q, sext_d;
  logic                wr_q, wr_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                done_q, done_d;
  logic                mis_q, mis_d;

  logic [31:0]         mem_q [DEPTH];
  logic [31:0]         mem_rd;
  logic [31:0]         wmerge;
  logic [31:0]         wd_sh;
  logic [31:0]         load_val;
  logic [3:0]          be;
  logic [7:0]          ld_b;
  logic [15:0]         ld_h;
  logic                mem_we;
  logic                req;
  logic                mis_req;
  logic                unused_hi;

  assign unused_hi = ^aluOut[31:ADDR_W+2];

  assign req     = MemRead | MemWrite;
  assign mis_req = ((size == 2'b01) & aluOut[0])
                 | (size[1] & (|aluOut[1:0]));

  assign mem_rd = mem_q[addr_q[ADDR_W+1:2]];

  // Lane enables and replicated store data for the captured access
  always_comb begin
    be    = 4'b0000;
    wd_sh = wdata_q;
    unique case (1'b1)
      (size_q == 2'b00): begin
        be    = 4'b0001 << addr_q[1:0];
        wd_sh = {4{wdata_q[7:0]}};
      end
      (size_q == 2'b01): begin
        be    = addr_q[1] ? 4'b1100 : 4'b0011;
        wd_sh = {2{wdata_q[15:0]}};
      end
      size_q[1]: begin
        be    = 4'b1111;
        wd_sh = wdata_q;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      wmerge[8*i +: 8] = be[i] ? wd_sh[8*i +: 8]
                               : mem_rd[8*i +: 8];
    end
  end

  always_comb begin
    ld_b     = mem_rd[8*addr_q[1:0] +: 8];
    ld_h     = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
    load_val = mem_rd;
    unique case (1'b1)
      (size_q == 2'b00):
        load_val = {{24{sext_q & ld_b[7]}}, ld_b};
      (size_q == 2'b01):
        load_val = {{16{sext_q & ld_h[15]}}, ld_h};
      size_q[1]:
        load_val = mem_rd;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    sext_d  = sext_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    mis_d   = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // done=1 means the held request is the one that just finished
        if (req && !done_q) begin
          if (mis_req) begin
            mis_d = 1'b1;
          end else begin
            addr_d  = aluOut[ADDR_W+1:0];
            wdata_d = writeData;
            size_d  = size;
            sext_d  = sign_ext;
            wr_d    = MemWrite;
            cnt_d   = 4'(WAIT_CYCLES);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
          if (wr_q) mem_we  = 1'b1;
          else      rdata_d = load_val;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= 32'd0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
    end
  end

  // Storage has no reset; a reset forces IDLE so no write can fire
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[addr_q[ADDR_W+1:2]] <= wmerge;
  end

  assign stall = rst_n & ((state_q == WAIT)
               | (req & !mis_req & !done_q));

  assign readData   = rdata_q;
  assign done       = done_q;
  assign misaligned = mis_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit.
// Two instances: WAIT_CYCLES=2 (a) and WAIT_CYCLES=0 (b).
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mr = 1'b0, mw = 1'b0, sx = 1'b0;
  logic [1:0]  sz = 2'b00;
  logic [31:0] addr = 32'd0, wd = 32'd0;
  logic        sel = 1'b0;

  logic [31:0] rd_a, rd_b;
  logic        stall_a, stall_b, done_a, done_b, mis_a, mis_b;

  int total = 0;
  int bad   = 0;
  int run_a = 0;
  int run_b = 0;

  typedef struct {
    int          inst;
    bit          mis;
    logic [31:0] rd;
    int          st;
    string       nm;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(8), .WAIT_CYCLES(2)) u_a (
    .clk(clk), .rst_n(rst_n),
    .MemRead(mr & ~sel), .MemWrite(mw & ~sel),
    .size(sz), .sign_ext(sx), .aluOut(addr), .writeData(wd),
    .readData(rd_a), .stall(stall_a), .done(done_a),
    .misaligned(mis_a)
  );

  mem_access_unit #(.ADDR_W(8), .WAIT_CYCLES(0)) u_b (
    .clk(clk), .rst_n(rst_n),
    .MemRead(mr & sel), .MemWrite(mw & sel),
    .size(sz), .sign_ext(sx), .aluOut(addr), .writeData(wd),
    .readData(rd_b), .stall(stall_b), .done(done_b),
    .misaligned(mis_b)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic sb_check(input int inst, input logic d,
                          input logic m, input logic [31:0] rd,
                          input int run);
    exp_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected inst%0d done=%b mis=%b rd=%h",
               inst, d, m, rd);
      return;
    end
    e = exp_q.pop_front();
    if (e.inst != inst || m !== e.mis || d !== !e.mis
        || rd !== e.rd || run != e.st) begin
      bad++;
      $display("FAIL %s: got inst%0d done=%b mis=%b rd=%h stall=%0d want inst%0d mis=%b rd=%h stall=%0d",
               e.nm, inst, d, m, rd, run, e.inst, e.mis, e.rd, e.st);
    end
  endtask

  // Monitor: measure stall length and pop on every done/misaligned
  always @(negedge clk) begin
    if (!rst_n) begin
      run_a = 0;
      run_b = 0;
    end else begin
      if (stall_a) run_a++;
      if (stall_b) run_b++;
      if (done_a || mis_a) begin
        sb_check(0, done_a, mis_a, rd_a, run_a);
        run_a = 0;
      end
      if (done_b || mis_b) begin
        sb_check(1, done_b, mis_b, rd_b, run_b);
        run_b = 0;
      end
    end
  end

  task automatic access(input string nm, input bit w, input bit r,
                        input logic [1:0] s, input bit se,
                        input logic [31:0] a, input logic [31:0] d,
                        input bit emis, input logic [31:0] erd,
                        input int est, input bit hold);
    exp_t e;
    bit   ok = 1'b0;
    e.inst = sel ? 1 : 0;
    e.mis  = emis;
    e.rd   = erd;
    e.st   = est;
    e.nm   = nm;
    exp_q.push_back(e);
    mw = w; mr = r; sz = s; sx = se; addr = a; wd = d;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk); #1;
      if (!(sel ? stall_b : stall_a)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s: stall never released", nm);
    end
    if (hold) begin
      @(posedge clk); #1;
    end
    mw = 0; mr = 0;
    repeat (2) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    mr = 1'b1;
    addr = 32'h10;
    sz = 2'b10;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd", rd_a, 32'h0);
    chk("rst_stall", {31'd0, stall_a}, 32'd0);
    chk("rst_done", {31'd0, done_a}, 32'd0);
    chk("rst_mis", {31'd0, mis_a}, 32'd0);
    mr = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    sel = 1'b0;
    access("sw_10", 1, 0, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0, 4, 0);
    access("lw_10", 0, 1, 2'b10, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 4, 0);
    access("sb_13", 1, 0, 2'b00, 0, 32'h13, 32'h80, 0, 32'hDEADBEEF, 4, 0);
    access("lb_13", 0, 1, 2'b00, 1, 32'h13, 32'h0, 0, 32'hFFFFFF80, 4, 0);
    access("lbu_13", 0, 1, 2'b00, 0, 32'h13, 32'h0, 0, 32'h00000080, 4, 0);
    access("lw_10b", 0, 1, 2'b10, 1, 32'h10, 32'h0, 0, 32'h80ADBEEF, 4, 0);
    access("lh_11", 0, 1, 2'b01, 1, 32'h11, 32'h0, 1, 32'h80ADBEEF, 0, 0);
    access("lh_12", 0, 1, 2'b01, 1, 32'h12, 32'h0, 0, 32'hFFFF80AD, 4, 0);
    access("lhu_10", 0, 1, 2'b01, 0, 32'h10, 32'h0, 0, 32'h0000BEEF, 4, 0);
    access("sh_12", 1, 0, 2'b01, 0, 32'h12, 32'hCAFE1234, 0, 32'h0000BEEF, 4, 0);
    access("lw_sh", 0, 1, 2'b10, 0, 32'h10, 32'h0, 0, 32'h1234BEEF, 4, 0);
    access("sw_mis", 1, 0, 2'b10, 0, 32'h22, 32'h0, 1, 32'h1234BEEF, 0, 0);
    access("sw_20", 1, 0, 2'b10, 0, 32'h20, 32'h11111111, 0, 32'h1234BEEF, 4, 0);

    // Store aborted by reset while in WAIT
    mw = 1; mr = 0; sz = 2'b10; addr = 32'h20; wd = 32'h55;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("abort_stall", {31'd0, stall_a}, 32'd0);
    chk("abort_done", {31'd0, done_a}, 32'd0);
    @(posedge clk); #1;
    mw = 0;
    rst_n = 1'b1;
    chk("abort_rd", rd_a, 32'h0);
    @(posedge clk); #1;
    access("lw_20", 0, 1, 2'b10, 0, 32'h20, 32'h0, 0, 32'h11111111, 4, 0);
    access("rw_24", 1, 1, 2'b10, 0, 32'h24, 32'h7, 0, 32'h11111111, 4, 0);
    access("lw_24", 0, 1, 2'b11, 1, 32'h24, 32'h0, 0, 32'h00000007, 4, 0);
    access("lw_wrap", 0, 1, 2'b10, 0, 32'h424, 32'h0, 0, 32'h00000007, 4, 0);

    sel = 1'b1;
    access("b_sw_400", 1, 0, 2'b10, 0, 32'h400, 32'hA5, 0, 32'h0, 2, 1);
    access("b_lw_000", 0, 1, 2'b10, 0, 32'h000, 32'h0, 0, 32'h000000A5, 2, 1);
    access("b_lbu_400", 0, 1, 2'b00, 1, 32'h400, 32'h0, 0, 32'hFFFFFFA5, 2, 1);
    access("b_mis", 0, 1, 2'b10, 0, 32'h402, 32'h0, 1, 32'hFFFFFFA5, 0, 0);

    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 32'd0);
    chk("a_rd_hold", rd_a, 32'h00000007);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
